// File: rtl/mem_access_fsm.sv
// mem_access_fsm: memory-stage access sequencer.
// Launches one request/acknowledge transaction per load or store held in
// EX/MEM and stalls the pipeline until it completes or times out. It then
// returns the load data, or a bus-error pulse on timeout, to write-back.
module mem_access_fsm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Final REQ cycle index before the access is abandoned.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_r,   state_nxt_s;
    logic [CNT_W-1:0]  cnt_r,     cnt_nxt_s;
    logic              req_r,     req_nxt_s;
    logic              we_r,      we_nxt_s;
    logic [ADDR_W-1:0] addr_r,    addr_nxt_s;
    logic [DATA_W-1:0] wdata_r,   wdata_nxt_s;
    logic [DATA_W-1:0] rdata_r,   rdata_nxt_s;
    logic              rvalid_r,  rvalid_nxt_s;
    logic              berr_r,    berr_nxt_s;
    logic              access_s;
    logic              stall_s;

    assign access_s = memread | memwrite;

    // Next-state and next-output logic.
    // While in REQ, a cycle with mem_ack completes the access, even on the
    // last permitted cycle. DONE ignores memread/memwrite because they still
    // show the retiring instruction.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        req_nxt_s    = req_r;
        we_nxt_s     = we_r;
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        rdata_nxt_s  = rdata_r;
        rvalid_nxt_s = 1'b0;
        berr_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    state_nxt_s = REQ;
                    cnt_nxt_s   = '0;
                    req_nxt_s   = 1'b1;
                    we_nxt_s    = memwrite;
                    addr_nxt_s  = addr;
                    wdata_nxt_s = wdata;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt_s = DONE;
                    req_nxt_s   = 1'b0;
                    if (!we_r) begin
                        rdata_nxt_s  = mem_rdata;
                        rvalid_nxt_s = 1'b1;
                    end else begin
                        rdata_nxt_s  = rdata_r;
                    end
                end else if (cnt_r == TO_LAST) begin
                    state_nxt_s = DONE;
                    req_nxt_s   = 1'b0;
                    rdata_nxt_s = '0;
                    berr_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                req_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // Pipeline hold: a pending launch in IDLE or an outstanding request.
    // Forced low during reset so the pipeline is released at once.
    always_comb begin
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((state_r == IDLE) && access_s) || (state_r == REQ);
        end
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            req_r    <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
            berr_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            req_r    <= req_nxt_s;
            we_r     <= we_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            rdata_r  <= rdata_nxt_s;
            rvalid_r <= rvalid_nxt_s;
            berr_r   <= berr_nxt_s;
        end
    end

    assign mem_stall   = stall_s;
    assign mem_req     = req_r;
    assign mem_we      = we_r;
    assign mem_addr    = addr_r;
    assign mem_wdata   = wdata_r;
    assign rdata       = rdata_r;
    assign rdata_valid = rvalid_r;
    assign bus_err     = berr_r;

endmodule

// File: tb/tb_mem_access_fsm.sv
// Bench for mem_access_fsm. It applies a table of accesses; each record
// holds the stimulus and the expected outcome. A monitor compares the
// records in queue order when each access reaches DONE. Hand-written
// sequences cover reset, idle behaviour and reset during a request.
module tb_mem_access_fsm;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'hBAD0BAD0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;

    mem_access_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .mem_stall(mem_stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata(rdata),
        .rdata_valid(rdata_valid), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_at;     // REQ cycle carrying mem_ack, 0 = never
        logic [31:0] rd;
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_rdata;
        logic        exp_rv;
        logic        exp_be;
        int          exp_gap;    // cycles between mem_req rises, 0 = unchecked
    } vec_t;

    vec_t vecs[9];
    vec_t q[$];

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: counts stall and request cycles, checks latched
    // request fields, and pops one expected record per completed access.
    int   cyc = 0;
    int   stall_cnt = 0;
    int   req_cnt = 0;
    int   last_rise = 0;
    logic prev_req = 1'b0;
    logic prev_done = 1'b0;
    vec_t e;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!mon_en) begin
            stall_cnt = 0;
            req_cnt   = 0;
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                check("pulse_rv_after_done", {63'h0, rdata_valid}, 64'h0);
                check("pulse_be_after_done", {63'h0, bus_err}, 64'h0);
                check("no_relaunch_from_done", {63'h0, mem_req}, 64'h0);
            end
            prev_done = 1'b0;
            if (mem_stall) stall_cnt++;
            if (mem_req) begin
                if (q.size() == 0) begin
                    check("unexpected_req", 64'h1, 64'h0);
                end else begin
                    if (!prev_req) begin
                        if (q[0].exp_gap != 0)
                            check("req_gap", 64'(cyc - last_rise), 64'(q[0].exp_gap));
                        last_rise = cyc;
                    end
                    check("mem_we", {63'h0, mem_we}, {63'h0, q[0].wr_en});
                    check("mem_addr", {32'h0, mem_addr}, {32'h0, q[0].a});
                    check("mem_wdata", {32'h0, mem_wdata}, {32'h0, q[0].wd});
                end
                req_cnt++;
            end else if (prev_req) begin
                if (q.size() == 0) begin
                    check("done_without_record", 64'h1, 64'h0);
                end else begin
                    e = q.pop_front();
                    check("stall_cycles", 64'(stall_cnt), 64'(e.exp_stall));
                    check("req_cycles", 64'(req_cnt), 64'(e.exp_req));
                    check("done_stall_low", {63'h0, mem_stall}, 64'h0);
                    check("rdata", {32'h0, rdata}, {32'h0, e.exp_rdata});
                    check("rdata_valid", {63'h0, rdata_valid}, {63'h0, e.exp_rv});
                    check("bus_err", {63'h0, bus_err}, {63'h0, e.exp_be});
                end
                stall_cnt = 0;
                req_cnt   = 0;
                prev_done = 1'b1;
            end
            prev_req = mem_req;
        end
    end

    // Drive one access from IDLE and answer its request; returns in DONE.
    task automatic run_vec(input vec_t v);
        int  rc;
        bit  seen;
        bit  fin;
        rc = 0; seen = 1'b0; fin = 1'b0;
        @(negedge clk);
        memread  = v.rd_en;
        memwrite = v.wr_en;
        addr     = v.a;
        wdata    = v.wd;
        mem_ack  = 1'b0;
        q.push_back(v);
        for (int c = 0; c < 4 * TO && !fin; c++) begin
            #1;
            if (mem_req) begin
                seen = 1'b1;
                rc++;
                mem_ack   = (rc == v.ack_at);
                mem_rdata = mem_ack ? v.rd : 32'hBAD0BAD0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0BAD0;
                if (seen) fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        check("access_completes", {63'h0, fin}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               rd    wr    addr          wdata         ack rd_data       stall req rdata         rv    be    gap
        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        1,  32'hDEADBEEF, 2,  1,  32'hDEADBEEF, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b1, 32'h40,  32'h12345678, 4,  32'h0,        5,  4,  32'hDEADBEEF, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        0,  32'h0,        16, 15, 32'h0,        1'b0, 1'b1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,        15, 32'hA5A5A5A5, 16, 15, 32'hA5A5A5A5, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h0,   32'h0,        1,  32'h11111111, 2,  1,  32'h11111111, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h4,   32'h0,        1,  32'h22222222, 2,  1,  32'h22222222, 1'b1, 1'b0, 3};
        vecs[6] = '{1'b1, 1'b1, 32'h60,  32'hCAFEF00D, 2,  32'h33333333, 3,  2,  32'h22222222, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b0, 1'b1, 32'h80,  32'h0F0F0F0F, 0,  32'h0,        16, 15, 32'h0,        1'b0, 1'b1, 0};
        vecs[8] = '{1'b1, 1'b0, 32'h700, 32'h0,        1,  32'h77777777, 2,  1,  32'h77777777, 1'b1, 1'b0, 0};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {63'h0, mem_stall}, 64'h0);
        check("rst_req", {63'h0, mem_req}, 64'h0);
        check("rst_we", {63'h0, mem_we}, 64'h0);
        check("rst_addr", {32'h0, mem_addr}, 64'h0);
        check("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        check("rst_rdata", {32'h0, rdata}, 64'h0);
        check("rst_rv", {63'h0, rdata_valid}, 64'h0);
        check("rst_be", {63'h0, bus_err}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory instructions: no stall, nothing launches or changes.
        addr  = 32'h5555AAAA;
        wdata = 32'h01234567;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("idle_stall", {63'h0, mem_stall}, 64'h0);
            check("idle_req", {63'h0, mem_req}, 64'h0);
            check("idle_addr", {32'h0, mem_addr}, 64'h0);
        end

        // Table of accesses issued back to back.
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'h0);
        mon_en = 1'b0;

        // Reset asserted on REQ cycle 2 of a pending load.
        @(negedge clk);
        memread = 1'b1;
        addr    = 32'h500;
        @(negedge clk);
        #1;
        check("abort_req_c1", {63'h0, mem_req}, 64'h1);
        @(negedge clk);
        #1;
        check("abort_req_c2", {63'h0, mem_req}, 64'h1);
        rst = 1'b1;
        #1;
        check("abort_req_low", {63'h0, mem_req}, 64'h0);
        check("abort_stall_low", {63'h0, mem_stall}, 64'h0);
        check("abort_rv_low", {63'h0, rdata_valid}, 64'h0);
        check("abort_be_low", {63'h0, bus_err}, 64'h0);
        memread = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("late_ack_req", {63'h0, mem_req}, 64'h0);
            check("late_ack_stall", {63'h0, mem_stall}, 64'h0);
            check("late_ack_rv", {63'h0, rdata_valid}, 64'h0);
            check("late_ack_rdata", {32'h0, rdata}, 64'h0);
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;

        // A fresh access completes normally after the abort.
        mon_en = 1'b1;
        run_vec(vecs[8]);
        @(negedge clk);
        memread = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained_end", 64'(q.size()), 64'h0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_fsm.md
# mem_access_fsm

Memory-stage access sequencer for the pipelined RISC-V core. It consumes the `memread`/`memwrite` control bits that the main controller produces and the EX/MEM register carries. It runs a request/acknowledge handshake to the data memory and holds the pipeline with `mem_stall` until the access completes or times out. It also returns load data and a bus-error pulse to the write-back path.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15: maximum number of REQ cycles without `mem_ack` before abort. Legal range is 1..255.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `memread` in 1: load in the memory stage (from EX/MEM).
- `memwrite` in 1: store in the memory stage (from EX/MEM).
- `addr` in ADDR_W: effective address from the ALU result.
- `wdata` in DATA_W: store data.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- `mem_req` out 1: request to data memory.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr` out ADDR_W: latched address; valid while `mem_req`.
- `mem_wdata` out DATA_W: latched store data; valid while `mem_req`.
- `mem_ack` in 1: memory completion; sampled only in REQ.
- `mem_rdata` in DATA_W: read data; valid with `mem_ack`.
- `rdata` out DATA_W: registered load result.
- `rdata_valid` out 1: one-cycle pulse when `rdata` holds a completed load.
- `bus_err` out 1: one-cycle pulse on timeout.

## Operation
- There are three states: IDLE, REQ and DONE. Reset state is IDLE.
- IDLE:
  - If `memread|memwrite`, latch `addr`, `wdata` and `mem_we` (= `memwrite`), clear the timeout counter, and go to REQ.
  - `memwrite` has priority if both inputs are high.
  - Otherwise stay in IDLE.
- REQ:
  - `mem_req`=1.
  - If `mem_ack`: capture `mem_rdata` into `rdata` when reading (`rdata` unchanged on write), set `rdata_valid` for reads, and go to DONE.
  - Else if the counter equals TIMEOUT-1: drop the request, load `rdata`=0, pulse `bus_err`, and go to DONE. `rdata_valid` stays 0.
  - Else increment the counter.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - `memread`/`memwrite` are ignored in DONE, because they still show the same, now-retiring instruction.
- `mem_stall` is combinational: (IDLE & (`memread`|`memwrite`)) | REQ. It is 0 in DONE, so EX/MEM advances at the end of DONE.
- `mem_req` is registered: high exactly during REQ.
- `mem_we`, `mem_addr` and `mem_wdata` hold their latched values until the next IDLE launch.
- `mem_ack` in IDLE or DONE is ignored.
- The counter is `$clog2(TIMEOUT+1)` bits wide; it is cleared on entry to REQ and never wraps.
- Reset values: `mem_stall`=0 (while no access is presented), `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, `rdata_valid`=0, `bus_err`=0, counter=0.

## Timing
- Fastest access:
  - Cycle 0: IDLE with access presented, `mem_stall`=1.
  - Cycle 1: REQ with `mem_req`=1 and `mem_ack`=1, `mem_stall`=1.
  - Cycle 2: DONE, `mem_stall`=0, `rdata`/`rdata_valid` valid.
  - The pipeline therefore stalls 2 cycles, plus N extra cycles for N wait cycles.
- `mem_ack` may arrive in the first REQ cycle.
- The latest accepted `mem_ack` is on REQ cycle TIMEOUT; an ack on that cycle wins over timeout.
- Timeout: after TIMEOUT REQ cycles without ack, DONE is entered, `bus_err`=1 for that one cycle, and the total stall is TIMEOUT+1 cycles.
- Back-to-back accesses: DONE forces one IDLE cycle between accesses. The next access launches from IDLE at the earliest on cycle DONE+1.
- `rst` asserted mid-REQ: `mem_req`, `mem_stall` and the pulses fall immediately (asynchronously); state becomes IDLE. A transaction aborted this way is not resumed.
- Non-memory instructions (both inputs 0) in IDLE produce no stall and no outputs change.

## Test plan
- Load with zero-wait ack: `memread`=1, `addr`=0x100, `mem_ack`=1 on the first REQ cycle, `mem_rdata`=0xDEADBEEF.
  -> `mem_stall` high for 2 cycles; `mem_req` high for 1 cycle with `mem_we`=0 and `mem_addr`=0x100; in DONE `rdata`=0xDEADBEEF and `rdata_valid`=1.
- Store with 3 wait cycles: `memwrite`=1, `addr`=0x40, `wdata`=0x12345678, ack on REQ cycle 4.
  -> `mem_req` high for 4 cycles with `mem_we`=1 and `mem_wdata`=0x12345678; `mem_stall` high for 5 cycles; `rdata_valid`=0; `bus_err`=0.
- Timeout with TIMEOUT=15, no ack.
  -> `mem_req` high for 15 cycles then low; `bus_err` pulses once; `rdata`=0; `mem_stall` high for 16 cycles.
- Ack exactly on REQ cycle 15 with TIMEOUT=15, `mem_rdata`=0xA5A5A5A5.
  -> normal completion with `rdata`=0xA5A5A5A5 and no `bus_err`.
- Back-to-back loads to 0x0 and 0x4, each zero-wait.
  -> the second `mem_req` rises exactly 3 cycles after the first; each access produces exactly one `rdata_valid` pulse; DONE never relaunches.
- `rst` pulsed on REQ cycle 2 of a pending load.
  -> `mem_req`, `mem_stall` and all pulses are 0 immediately; the block returns to IDLE; a late `mem_ack` after reset is ignored.
